// File: rtl/debug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : debug_pkg                                                  |
// | Purpose : Shared constants for the pipeline debug unit: command      |
// |           bytes, FSM state codes and dump-stream geometry.           |
// | Options : DBG_CYCLE_COUNT_EN adds a cycle-count word to the dump.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package debug_pkg;

  // Command bytes received from the UART
  localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'

  // FSM state codes
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  // Every word in the dump stream is 32 bits, sent LSB byte first
  localparam int WORD_BITS  = 32;
  localparam int WORD_BYTES = WORD_BITS / 8;
  localparam int IDX_BITS   = 5;

  // Stream geometry for both builds
  localparam int         WORDS_BASE = 5;   // pc, instr, rs, rt, w
  localparam int         WORDS_CNT  = 6;   // plus cycle counter
  localparam logic [4:0] LAST_BASE  = 5'd19;
  localparam logic [4:0] LAST_CNT   = 5'd23;

`ifdef DBG_CYCLE_COUNT_EN
  localparam int         NUM_WORDS = WORDS_CNT;
  localparam logic [4:0] LAST_IDX  = LAST_CNT;
`else
  localparam int         NUM_WORDS = WORDS_BASE;
  localparam logic [4:0] LAST_IDX  = LAST_BASE;
`endif

  localparam int STREAM_BYTES = NUM_WORDS * WORD_BYTES;

endpackage
`default_nettype wire

// File: rtl/dbg_snapshot_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dbg_snapshot_mux                                           |
// | Purpose : Snapshot registers for the observed pipeline words and the |
// |           byte selector feeding the UART transmit path.              |
// | Options : DBG_CYCLE_COUNT_EN adds the cycle-count word input.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dbg_snapshot_mux
  import debug_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_capture,
  input  logic [WORD_BITS-1:0] i_pc_addr,
  input  logic [WORD_BITS-1:0] i_instr,
  input  logic [WORD_BITS-1:0] i_rs,
  input  logic [WORD_BITS-1:0] i_rt,
  input  logic [WORD_BITS-1:0] i_w,
`ifdef DBG_CYCLE_COUNT_EN
  input  logic [WORD_BITS-1:0] i_cycles,
`endif
  input  logic [IDX_BITS-1:0]  i_byte_idx,
  output logic [7:0]           o_byte
);

  logic [NUM_WORDS*WORD_BITS-1:0] r_snap;
  logic [NUM_WORDS*WORD_BITS-1:0] w_next;

  // Word 0 sits in the low bits so stream byte k is simply bits [8k +: 8]
`ifdef DBG_CYCLE_COUNT_EN
  assign w_next = {i_cycles, i_w, i_rt, i_rs, i_instr, i_pc_addr};
`else
  assign w_next = {i_w, i_rt, i_rs, i_instr, i_pc_addr};
`endif

  // Freeze the observed words when the FSM passes through LATCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
    end else if (i_capture) begin
      r_snap <= w_next;
    end
  end

  // Byte select; indices past the stream end read as zero
  always_comb begin
    o_byte = 8'h00;
    for (int k = 0; k < STREAM_BYTES; k++) begin
      if (i_byte_idx == IDX_BITS'(k)) begin
        o_byte = r_snap[k*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : debug_unit                                                 |
// | Purpose : UART-driven run/step/reset control of the MIPS pipeline,   |
// |           HALT detection and byte-serial dump of the debug words.    |
// | Options : DBG_CYCLE_COUNT_EN counts enabled cycles and appends the   |
// |           count as a sixth dump word (24 bytes instead of 20).       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module debug_unit
  import debug_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_BITS  = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_done,
  output logic                  pc_enable,
  output logic                  pc_reset,
  input  logic [ADDR_BITS-1:0]  pc_addr_in,
  input  logic [DATA_WIDTH-1:0] pc_instr_in,
  input  logic [DATA_WIDTH-1:0] reg_rs_in,
  input  logic [DATA_WIDTH-1:0] reg_rt_in,
  input  logic [DATA_WIDTH-1:0] reg_w_in,
  output logic                  halted
);

  logic [2:0]          r_state;
  logic [IDX_BITS-1:0] r_byte_idx;
  logic                r_pc_enable;
  logic                r_pc_reset;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic                r_halted;
  logic [7:0]          w_byte;
  logic                w_is_halt;

  assign w_is_halt = (pc_instr_in == HALT_INSTR);

`ifdef DBG_CYCLE_COUNT_EN
  logic                 w_cmd_reset;
  logic [WORD_BITS-1:0] r_cycles;

  // An accepted 'R' is only possible from IDLE or RUN
  assign w_cmd_reset = rx_valid && (rx_data == CMD_RESET) &&
                       ((r_state == ST_IDLE) || (r_state == ST_RUN));

  // Count cycles in which the pipeline advanced; wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (w_cmd_reset) begin
      r_cycles <= '0;
    end else if (r_pc_enable) begin
      r_cycles <= r_cycles + WORD_BITS'(1);
    end
  end
`endif

  dbg_snapshot_mux u_snap (
    .clk        (clk),
    .rst        (reset),
    .i_capture  (r_state == ST_LATCH),
    .i_pc_addr  (WORD_BITS'(pc_addr_in)),
    .i_instr    (WORD_BITS'(pc_instr_in)),
    .i_rs       (WORD_BITS'(reg_rs_in)),
    .i_rt       (WORD_BITS'(reg_rt_in)),
    .i_w        (WORD_BITS'(reg_w_in)),
`ifdef DBG_CYCLE_COUNT_EN
    .i_cycles   (r_cycles),
`endif
    .i_byte_idx (r_byte_idx),
    .o_byte     (w_byte)
  );

  // Control FSM; pc_reset and tx_start are single-cycle pulses by default
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_byte_idx  <= '0;
      r_pc_enable <= 1'b0;
      r_pc_reset  <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_halted    <= 1'b0;
    end else begin
      r_pc_reset <= 1'b0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            if ((rx_data == CMD_RUN) && !r_halted) begin
              r_state     <= ST_RUN;
              r_pc_enable <= 1'b1;
            end else if ((rx_data == CMD_STEP) && !r_halted) begin
              r_state     <= ST_STEP;
              r_pc_enable <= 1'b1;
            end else if (rx_data == CMD_DUMP) begin
              r_state <= ST_LATCH;
            end else if (rx_data == CMD_RESET) begin
              r_pc_reset <= 1'b1;
              r_halted   <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          // 'R' has priority over a coincident HALT
          if (rx_valid && (rx_data == CMD_RESET)) begin
            r_pc_enable <= 1'b0;
            r_pc_reset  <= 1'b1;
            r_halted    <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_is_halt) begin
            r_pc_enable <= 1'b0;
            r_halted    <= 1'b1;
            r_state     <= ST_LATCH;
          end
        end
        ST_STEP: begin
          r_pc_enable <= 1'b0;
          if (w_is_halt) begin
            r_halted <= 1'b1;
          end
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_byte_idx <= '0;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_tx_data  <= w_byte;
          r_tx_start <= 1'b1;
          r_state    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done) begin
            if (r_byte_idx == LAST_IDX) begin
              r_state <= ST_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + IDX_BITS'(1);
              r_state    <= ST_SEND;
            end
          end
        end
        default: begin
          r_pc_enable <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc_enable = r_pc_enable;
  assign pc_reset  = r_pc_reset;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign halted    = r_halted;

endmodule
`default_nettype wire

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Control-and-observe stage wrapped around the 5-stage MIPS pipeline top. It decodes command bytes from a UART receiver and drives the pipeline's pc_enable and pc_reset, in run, single-step or reset mode. It detects the HALT instruction in fetch. On halt, step or dump it snapshots the pipeline debug outputs and streams them out byte-by-byte to a UART transmitter.

Parameters:
- DATA_WIDTH, 32, width of every observed pipeline word.
- ADDR_BITS, 32, width of the observed PC.
- HALT_INSTR, 32'hFFFF_FFFF, instruction word that stops continuous run.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received command byte.
- rx_valid  in  1  one-cycle pulse; rx_data valid this cycle.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_done  in  1  one-cycle pulse; transmitter has finished the current byte.
- pc_enable  out  1  to pipeline; advances all stages when 1.
- pc_reset  out  1  to pipeline; synchronous pipeline reset pulse.
- pc_addr_in  in  ADDR_BITS  pipeline fetch PC.
- pc_instr_in  in  DATA_WIDTH  pipeline fetched instruction.
- reg_rs_in, reg_rt_in, reg_w_in  in  DATA_WIDTH each  pipeline register-file / write-back debug words.
- halted  out  1  HALT seen; sticky until 'R'.

Behaviour:
- Reset values:
  - state = IDLE.
  - pc_enable = 0, pc_reset = 0, tx_start = 0, tx_data = 8'h00, halted = 0.
  - Byte index = 0; snapshot registers = 0.
- All outputs are registered. Command codes:
  - 'C' 8'h43 = run.
  - 'S' 8'h53 = step.
  - 'R' 8'h52 = reset.
  - 'D' 8'h44 = dump.
- IDLE:
  - rx_valid with 'C' and !halted -> RUN; pc_enable = 1 from the next cycle.
  - 'S' and !halted -> STEP.
  - 'D' -> LATCH.
  - 'R' -> pc_reset = 1 for exactly one cycle, halted cleared, stay IDLE.
  - Any other byte, or 'C'/'S' while halted, is ignored.
- RUN:
  - pc_enable = 1 every cycle.
  - When pc_instr_in == HALT_INSTR is sampled: pc_enable = 0 next cycle, halted = 1 -> LATCH.
  - rx 'R' during RUN -> pc_enable = 0, one-cycle pc_reset, -> IDLE, no dump.
  - All other rx bytes are ignored.
  - HALT and 'R' in the same cycle: 'R' wins.
- STEP: pc_enable = 1 for exactly one cycle, then -> LATCH. A HALT observed on the stepped instruction sets halted.
- LATCH:
  - Capture pc_addr_in, pc_instr_in, reg_rs_in, reg_rt_in, reg_w_in into the snapshot.
  - Byte index = 0 -> SEND.
- SEND: tx_data = snapshot byte[index], tx_start = 1 for one cycle -> WAIT_TX.
- WAIT_TX:
  - On tx_done, if index == LAST -> IDLE.
  - Otherwise index + 1 -> SEND.
- Stream order and length:
  - Words are sent in order pc_addr, pc_instr, rs, rt, w.
  - Each word is sent LSB byte first.
  - LAST = 19, i.e. 20 bytes.
- rx_valid in LATCH/SEND/WAIT_TX is dropped, including when coincident with tx_done.
- tx_done outside WAIT_TX is ignored.
- Async reset mid-transfer: immediate return to reset values; the partial stream is abandoned.
- pc_enable is never 1 outside RUN/STEP. pc_reset and pc_enable are never 1 in the same cycle.

Optional Feature:
DBG_CYCLE_COUNT_EN
- Defined:
  - A 32-bit counter increments each cycle pc_enable = 1; it wraps at 2^32.
  - It clears on reset and on 'R'.
  - It is latched in LATCH and appended as a 6th word, so LAST = 23 (24 bytes).
- Undefined: no counter; LAST = 19.

Decomposition:
- Package debug_pkg holds:
  - Command code constants.
  - State enum (IDLE, RUN, STEP, LATCH, SEND, WAIT_TX).
  - Word count and LAST constants under both macro settings.
- One natural sub-module: dbg_snapshot_mux.
  - Holds the snapshot registers and the byte-select mux indexed by byte index.
  - The FSM stays in debug_unit.

Test Plan:
- Reset, then 'S' with PC=0x04, instr=0x2001000A -> pc_enable high 1 cycle. Then 20 tx_start pulses: bytes 04 00 00 00 0A 00 01 20 …; halted = 0.
- 'C' with HALT_INSTR presented after 7 cycles -> pc_enable high 7 cycles then low, halted = 1, 20-byte dump. A following 'C' and 'S' are ignored.
- 'R' while halted -> pc_reset one-cycle pulse, halted = 0, no tx_start. A following 'C' is accepted.
- 'D' sent while in WAIT_TX, coincident with tx_done -> 'D' dropped; the stream continues to exactly 20 bytes.
- Async reset asserted after byte 9 of a dump -> tx_start stops, all outputs at reset values; a new 'D' restarts from byte 0.
- With DBG_CYCLE_COUNT_EN: 'C', 12 enabled cycles to HALT -> 24 bytes, last word 0x0000000C.
